// File: rtl/lsu_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage_if
// Purpose  : Data-memory port bundle between the LSU stage (master) and the
//            data memory (slave): request/grant plus read response.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_stage_if #(
   parameter int XLEN = 32
);
   logic            mem_req;
   logic            mem_gnt;
   logic            mem_we;
   logic [3:0]      mem_be;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage
// Purpose  : Memory pipeline stage. Passes ALU results to writeback after one
//            cycle and runs loads/stores as request/grant/response
//            transactions with byte-lane steering, sign/zero extension and
//            misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_stage #(
   parameter int XLEN = 32
) (
   input  wire logic            clk,
   input  wire logic            rst,
   // EX-side handshake
   input  wire logic            ex_valid,
   output logic                 ex_ready,
   input  wire logic [1:0]      ex_op,
   input  wire logic [2:0]      ex_funct3,
   input  wire logic [XLEN-1:0] ex_addr,
   input  wire logic [XLEN-1:0] ex_wdata,
   input  wire logic [4:0]      ex_rd,
   // data-memory port
   lsu_stage_if.master          mem,
   // writeback
   output logic                 wb_valid,
   output logic                 wb_we,
   output logic [4:0]           wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic                 wb_fault
);

   localparam logic [1:0] OP_ALU   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t state, state_nxt;

   // transaction context captured at acceptance
   logic            is_store, is_store_nxt;
   logic [2:0]      f3_q, f3_nxt;
   logic [1:0]      lo_q, lo_nxt;
   logic [4:0]      rd_q, rd_nxt;

   // registered outputs
   logic            req_q, req_nxt;
   logic            we_q, we_nxt;
   logic [3:0]      be_q, be_nxt;
   logic [XLEN-1:0] addr_q, addr_nxt;
   logic [XLEN-1:0] wdata_q, wdata_nxt;
   logic            wbv_q, wbv_nxt;
   logic            wbwe_q, wbwe_nxt;
   logic [4:0]      wbrd_q, wbrd_nxt;
   logic [XLEN-1:0] wbdata_q, wbdata_nxt;
   logic            wbf_q, wbf_nxt;

   // decode of the incoming operation
   logic            is_ld, is_st;
   logic            f3_ok_ld, f3_ok_st;
   logic            misal;
   logic            fault;
   logic [3:0]      be_dec;
   logic [XLEN-1:0] wdata_dec;
   logic [XLEN-1:0] lane;
   logic [XLEN-1:0] load_val;

   assign ex_ready      = (state == ST_IDLE);

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign wb_valid      = wbv_q;
   assign wb_we         = wbwe_q;
   assign wb_rd         = wbrd_q;
   assign wb_data       = wbdata_q;
   assign wb_fault      = wbf_q;

   // classify the EX operation: legality, alignment, lane enables, store data
   always_comb begin
      is_ld    = (ex_op == OP_LOAD);
      is_st    = (ex_op == OP_STORE);
      f3_ok_ld = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) ||
                 (ex_funct3 == 3'b010) || (ex_funct3 == 3'b100) ||
                 (ex_funct3 == 3'b101);
      f3_ok_st = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) ||
                 (ex_funct3 == 3'b010);
      // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
      misal    = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
      fault    = (ex_op == 2'b11) ||
                 (is_ld && !f3_ok_ld) ||
                 (is_st && !f3_ok_st) ||
                 ((is_ld || is_st) && misal);

      case (ex_funct3[1:0])
         2'b00:   be_dec = 4'b0001 << ex_addr[1:0];
         2'b01:   be_dec = 4'b0011 << ex_addr[1:0];
         default: be_dec = 4'b1111;
      endcase

      case (ex_funct3[1:0])
         2'b00:   wdata_dec = {4{ex_wdata[7:0]}};
         2'b01:   wdata_dec = {2{ex_wdata[15:0]}};
         default: wdata_dec = ex_wdata;
      endcase
   end

   // align the addressed lane to bit 0 and extend to the full width
   always_comb begin
      lane = mem.mem_rdata >> {lo_q, 3'b000};
      case (f3_q)
         3'b000:  load_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, lane[7:0]};
         3'b001:  load_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   // next-state and next-output logic; every register holds unless updated
   always_comb begin
      state_nxt    = state;
      is_store_nxt = is_store;
      f3_nxt       = f3_q;
      lo_nxt       = lo_q;
      rd_nxt       = rd_q;
      req_nxt      = req_q;
      we_nxt       = we_q;
      be_nxt       = be_q;
      addr_nxt     = addr_q;
      wdata_nxt    = wdata_q;
      wbv_nxt      = 1'b0;
      wbwe_nxt     = wbwe_q;
      wbrd_nxt     = wbrd_q;
      wbdata_nxt   = wbdata_q;
      wbf_nxt      = wbf_q;

      case (state)
         ST_IDLE: begin
            if (ex_valid) begin
               if (ex_op == OP_ALU) begin
                  wbv_nxt    = 1'b1;
                  wbwe_nxt   = (ex_rd != 5'd0);
                  wbrd_nxt   = ex_rd;
                  wbdata_nxt = ex_addr;
                  wbf_nxt    = 1'b0;
               end else if (fault) begin
                  // report immediately, never touch memory
                  wbv_nxt    = 1'b1;
                  wbwe_nxt   = 1'b0;
                  wbrd_nxt   = ex_rd;
                  wbdata_nxt = ex_addr;
                  wbf_nxt    = 1'b1;
               end else begin
                  is_store_nxt = is_st;
                  f3_nxt       = ex_funct3;
                  lo_nxt       = ex_addr[1:0];
                  rd_nxt       = ex_rd;
                  req_nxt      = 1'b1;
                  we_nxt       = is_st;
                  be_nxt       = be_dec;
                  addr_nxt     = {ex_addr[XLEN-1:2], 2'b00};
                  wdata_nxt    = wdata_dec;
                  state_nxt    = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            // request fields stay frozen until the memory grants
            if (mem.mem_gnt) begin
               req_nxt = 1'b0;
               we_nxt  = 1'b0;
               if (is_store) begin
                  wbv_nxt   = 1'b1;
                  wbwe_nxt  = 1'b0;
                  wbrd_nxt  = rd_q;
                  wbf_nxt   = 1'b0;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (mem.mem_rvalid) begin
               wbv_nxt    = 1'b1;
               wbwe_nxt   = (rd_q != 5'd0);
               wbrd_nxt   = rd_q;
               wbdata_nxt = load_val;
               wbf_nxt    = 1'b0;
               state_nxt  = ST_IDLE;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // context and output registers; reset abandons any open transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         is_store <= 1'b0;
         f3_q     <= 3'd0;
         lo_q     <= 2'd0;
         rd_q     <= 5'd0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 4'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wbv_q    <= 1'b0;
         wbwe_q   <= 1'b0;
         wbrd_q   <= 5'd0;
         wbdata_q <= '0;
         wbf_q    <= 1'b0;
      end else begin
         is_store <= is_store_nxt;
         f3_q     <= f3_nxt;
         lo_q     <= lo_nxt;
         rd_q     <= rd_nxt;
         req_q    <= req_nxt;
         we_q     <= we_nxt;
         be_q     <= be_nxt;
         addr_q   <= addr_nxt;
         wdata_q  <= wdata_nxt;
         wbv_q    <= wbv_nxt;
         wbwe_q   <= wbwe_nxt;
         wbrd_q   <= wbrd_nxt;
         wbdata_q <= wbdata_nxt;
         wbf_q    <= wbf_nxt;
      end
   end

endmodule
`default_nettype wire

// File: doc/lsu_stage.md
# lsu_stage

Memory stage placed directly after the ALU in the pipeline. Latches the ALU result together with the decoded memory operation. Non-memory results pass through to writeback after one cycle. Loads and stores are run as a request/grant/response transaction on the data-memory port, with byte-lane steering, sign/zero extension and misalignment detection.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: the EX stage presents an operation.
- `ex_ready` out 1: the stage accepts an operation this cycle.
- `ex_op` in 2: operation type.
  - 00: ALU result only.
  - 01: load.
  - 10: store.
  - 11: reserved, treated as a fault.
- `ex_funct3` in 3: RV32I load/store funct3.
- `ex_addr` in XLEN: ALU result; this is the effective address for loads and stores.
- `ex_wdata` in XLEN: rs2 value, used as store data.
- `ex_rd` in 5: destination register.
- `mem_req` out 1: memory request.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_we` out 1: request is a write.
- `mem_be` out 4: byte enables.
- `mem_addr` out XLEN: word-aligned address.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_rvalid` in 1: read data is valid.
- `mem_rdata` in XLEN: read data.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_we` out 1: register-file write enable.
- `wb_rd` out 5: destination register.
- `wb_data` out XLEN: writeback value.
- `wb_fault` out 1: misaligned access, illegal funct3, or reserved op. Valid only while `wb_valid` is high.

## Operation
- States: IDLE, REQ, WAIT.
- `ex_ready` = (state == IDLE).
- An operation is accepted on `ex_valid && ex_ready`. At acceptance the stage registers the op, funct3, `addr[1:0]`, rd and the steered store data.
- Pass-through (op 00):
  - Next cycle: `wb_valid`=1, `wb_data`=`ex_addr`, `wb_we`=(rd≠0).
  - State stays IDLE, so back-to-back acceptance is possible every cycle.
- Fault conditions:
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - op 11.
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
- On a fault:
  - Next cycle: `wb_valid`=1, `wb_fault`=1, `wb_we`=0, `wb_data`=`ex_addr`.
  - No memory request is issued. State stays IDLE.
- Legal load or store: go to REQ.
  - `mem_req`=1.
  - `mem_addr`={addr[31:2],2'b00}.
  - `mem_we`=store.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are held stable until `mem_gnt`.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - Loads drive the same enables.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Store granted in REQ: next cycle `wb_valid`=1, `wb_we`=0; return to IDLE.
- Load granted in REQ: go to WAIT. `mem_req`=0 in WAIT.
- On `mem_rvalid` in WAIT: next cycle `wb_valid`=1, `wb_we`=(rd≠0), `wb_data`=extracted value; return to IDLE.
- Load extraction:
  - The lane is `mem_rdata >> (8*addr[1:0])`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW uses the full word.
- `mem_rvalid` outside WAIT is ignored.
- `mem_gnt` outside REQ is ignored.

## Timing
- Reset values: state IDLE. The following outputs are 0: `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_we`, `wb_rd`, `wb_data`, `wb_fault`. Because state is IDLE, `ex_ready` is 1.
- Latency is counted from the acceptance edge (c0):
  - Pass-through and fault: `wb_valid` at c1.
  - Store with immediate grant: `mem_req` at c1, `wb_valid` at c2.
  - Load with grant at c1 and rvalid at c2: `wb_valid` at c3.
- Each cycle of grant or rvalid delay adds one cycle of latency.
- `wb_valid` is never high for two consecutive cycles of the same operation.
- The memory guarantees `mem_rvalid` no earlier than the cycle after `mem_gnt`.
- Reset asserted in REQ or WAIT abandons the transaction: `mem_req` drops the next cycle and no `wb_valid` is produced. A late `mem_rvalid` is then ignored in IDLE.
- `ex_valid` while `ex_ready`=0 is not accepted. The upstream stage holds its operation.

## Test plan
- Pass-through: addr 0x11, 0x22, 0x33 on consecutive cycles with rd=5 -> `wb_valid` on three consecutive cycles with the same data; `wb_we`=1. Repeat with rd=0 -> `wb_we`=0.
- LB at addr 0x1003, rdata 0x80112233, grant immediate, rvalid one cycle later -> `mem_addr` 0x1000, `mem_be` 1000, `wb_data` 0xFFFFFF80 at c3. LBU with the same stimulus -> 0x00000080.
- SH at 0x2002 with wdata 0x1234BEEF, `mem_gnt` delayed 3 cycles -> `mem_req` held 4 cycles with `mem_addr` 0x2000, `mem_be` 1100, `mem_wdata` 0xBEEFBEEF unchanged; `wb_valid` with `wb_we`=0 one cycle after the grant.
- LW at 0x1001 and SH at 0x3003 -> `wb_fault`=1, `wb_we`=0 at c1, `mem_req` never asserted. Load funct3=011 -> same response.
- LH at 0x4000, rdata 0x0000F00D -> 0xFFFFF00D. LHU at 0x4002, rdata 0x8001ABCD -> 0x00008001.
- Load granted, then `rst` pulsed in WAIT, then `mem_rvalid` -> no `wb_valid`, all outputs at reset values, `ex_ready`=1.
